// File: rtl/mem_responder.sv
// MemSplit32 slave: word-addressed RAM with byte-enable writes, pipelined reads of
// fixed latency, and a power-up sweep that clears every word before requests are taken.
module mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          RD_LAT    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        ack_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        resp_o,
  output logic [31:0] rdata_o,
  input  logic        stall_i,
  output logic        busy_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);
  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [AW-1:0]   init_cnt_r;
  logic [AW-1:0]   init_cnt_nxt_s;
  logic            init_we_s;

  logic [31:0]     mem_r [DEPTH];

  logic            in_range_s;
  logic [AW-1:0]   word_idx_s;
  logic            ack_s;
  logic            rd_acc_s;
  logic            wr_acc_s;
  logic            unused_s;

  logic [RD_LAT-1:0] vld_r;
  logic [31:0]       data_r [RD_LAT];

  // BASE_ADDR is aligned to the memory size, so range is a plain upper-bit match
  assign in_range_s = (addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign word_idx_s = addr_i[AW+1:2];
  assign unused_s   = ^addr_i[1:0];

  assign ack_s    = rst_i & (state_r == ST_READY) & req_i & ~stall_i;
  assign rd_acc_s = ack_s & ~we_i;
  assign wr_acc_s = ack_s & we_i & in_range_s;

  // FSM state and init-sweep counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r    <= ST_INIT;
      init_cnt_r <= {AW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      init_cnt_r <= init_cnt_nxt_s;
    end
  end

  // Next-state logic: sweep one word per cycle, then stay ready
  always_comb begin
    state_nxt_s    = state_r;
    init_cnt_nxt_s = init_cnt_r;
    init_we_s      = 1'b0;
    case (state_r)
      ST_INIT: begin
        init_we_s = 1'b1;
        if (init_cnt_r == CNT_LAST) begin
          state_nxt_s    = ST_READY;
          init_cnt_nxt_s = {AW{1'b0}};
        end else begin
          state_nxt_s    = ST_INIT;
          init_cnt_nxt_s = init_cnt_r + CNT_ONE;
        end
      end
      ST_READY: begin
        state_nxt_s    = ST_READY;
        init_cnt_nxt_s = {AW{1'b0}};
      end
      default: begin
        state_nxt_s    = ST_INIT;
        init_cnt_nxt_s = {AW{1'b0}};
      end
    endcase
  end

  // Memory array: init clear or byte-masked write; never reset so it maps to RAM
  always_ff @(posedge clk_i) begin
    if (rst_i && init_we_s) begin
      mem_r[init_cnt_r] <= 32'h0;
    end else if (wr_acc_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_r[word_idx_s][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read response pipeline; empty slots carry zero data so rdata_o is clean when idle
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vld_r <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        data_r[i] <= 32'h0;
      end
    end else begin
      vld_r[0] <= rd_acc_s;
      if (rd_acc_s) begin
        data_r[0] <= in_range_s ? mem_r[word_idx_s] : OOR_DATA;
      end else begin
        data_r[0] <= 32'h0;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i]  <= vld_r[i-1];
        data_r[i] <= data_r[i-1];
      end
    end
  end

  assign ack_o   = ack_s;
  assign resp_o  = rst_i & vld_r[RD_LAT-1];
  assign rdata_o = rst_i ? data_r[RD_LAT-1] : 32'h0;
  assign busy_o  = ~rst_i | (state_r == ST_INIT);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH=16, BASE_ADDR=0, RD_LAT=2).
// Inputs change at the falling edge; outputs are checked 1 ns later.
module tb_mem_responder;

  logic        clk;
  logic        rst_i;
  logic        req_i;
  logic        ack_o;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        resp_o;
  logic [31:0] rdata_o;
  logic        stall_i;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(
    .DEPTH     (16),
    .BASE_ADDR (32'h0),
    .RD_LAT    (2)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .ack_o   (ack_o),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .be_i    (be_i),
    .resp_o  (resp_o),
    .rdata_o (rdata_o),
    .stall_i (stall_i),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, settle 1 ns
  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b, input logic s);
    @(negedge clk);
    req_i = r; we_i = w; addr_i = a; wdata_i = d; be_i = b; stall_i = s;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h3C;
    wdata_i = 32'h0; be_i = 4'h0; stall_i = 1'b0;

    // Reset state with a request held high
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h3C, 32'h0, 4'h0, 1'b0);
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_busy", busy_o, 1'b1);
    chk("rst_resp", resp_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'h0);

    // Init sweep: 16 busy cycles, then the held read of 0x3C is accepted
    @(negedge clk); rst_i = 1'b1; #1;
    chk("init0_busy", busy_o, 1'b1);
    chk("init0_ack", ack_o, 1'b0);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b1, 1'b0, 32'h3C, 32'h0, 4'h0, (i == 5) ? 1'b1 : 1'b0);
      chk($sformatf("init%0d_busy", i), busy_o, 1'b1);
      chk($sformatf("init%0d_ack", i), ack_o, 1'b0);
    end
    cyc(1'b1, 1'b0, 32'h3C, 32'h0, 4'h0, 1'b0);
    chk("ready_busy", busy_o, 1'b0);
    chk("ready_ack", ack_o, 1'b1);
    idle();
    chk("r3c_t1_resp", resp_o, 1'b0);
    chk("r3c_t1_rdata", rdata_o, 32'h0);
    idle();
    chk("r3c_t2_resp", resp_o, 1'b1);
    chk("r3c_t2_rdata", rdata_o, 32'h0);
    idle();
    chk("r3c_t3_resp", resp_o, 1'b0);

    // Byte enables, including a be=0 write that must not modify the word
    cyc(1'b1, 1'b1, 32'h8, 32'h1122_3344, 4'hF, 1'b0);
    chk("wr8_ack", ack_o, 1'b1);
    cyc(1'b1, 1'b1, 32'h8, 32'hAABB_CCDD, 4'h2, 1'b0);
    cyc(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
    idle();
    chk("be_t1_resp", resp_o, 1'b0);
    idle();
    chk("be_t2_resp", resp_o, 1'b1);
    chk("be_t2_rdata", rdata_o, 32'h1122_CC44);
    cyc(1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0);
    idle();
    idle();
    chk("be0_rdata", rdata_o, 32'h1122_CC44);

    // Range: out-of-range read, aliasing write, ignored low address bits
    cyc(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    idle();
    idle();
    chk("oor_resp", resp_o, 1'b1);
    chk("oor_rdata", rdata_o, 32'hDEAD_BEEF);
    cyc(1'b1, 1'b1, 32'h40, 32'h5, 4'hF, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    idle();
    idle();
    chk("alias_resp", resp_o, 1'b1);
    chk("alias_rdata", rdata_o, 32'h0);
    cyc(1'b1, 1'b1, 32'h3D, 32'h1234_5678, 4'hF, 1'b0);
    cyc(1'b1, 1'b0, 32'h3F, 32'h0, 4'h0, 1'b0);
    idle();
    idle();
    chk("lowbits_rdata", rdata_o, 32'h1234_5678);

    // Streaming: four writes, four back-to-back reads, four consecutive responses
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    chk("str_r0_resp", resp_o, 1'b0);
    cyc(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    chk("str_r1_resp", resp_o, 1'b0);
    cyc(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
    chk("str_d0", rdata_o, 32'hA0);
    chk("str_v0", resp_o, 1'b1);
    cyc(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0);
    chk("str_d1", rdata_o, 32'hA1);
    idle();
    chk("str_d2", rdata_o, 32'hA2);
    idle();
    chk("str_d3", rdata_o, 32'hA3);
    chk("str_v3", resp_o, 1'b1);
    idle();
    chk("str_end_resp", resp_o, 1'b0);
    chk("str_end_rdata", rdata_o, 32'h0);

    // Stall: read accepted just before three stalled write requests
    cyc(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    chk("stl_t0_ack", ack_o, 1'b1);
    cyc(1'b1, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1);
    chk("stl_t1_ack", ack_o, 1'b0);
    chk("stl_t1_resp", resp_o, 1'b0);
    cyc(1'b1, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1);
    chk("stl_t2_ack", ack_o, 1'b0);
    chk("stl_t2_resp", resp_o, 1'b1);
    chk("stl_t2_rdata", rdata_o, 32'hA1);
    cyc(1'b1, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1);
    chk("stl_t3_ack", ack_o, 1'b0);
    chk("stl_t3_resp", resp_o, 1'b0);
    cyc(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    idle();
    idle();
    chk("stl_nowrite", rdata_o, 32'hA1);

    // Reset mid-flight: in-flight read dropped, full re-init, data cleared
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    chk("mf_ack", ack_o, 1'b1);
    @(negedge clk); rst_i = 1'b0; req_i = 1'b0; #1;
    chk("mf_rst_resp", resp_o, 1'b0);
    chk("mf_rst_busy", busy_o, 1'b1);
    @(negedge clk); rst_i = 1'b1; req_i = 1'b1; #1;
    chk("mf_init0_resp", resp_o, 1'b0);
    chk("mf_init0_busy", busy_o, 1'b1);
    chk("mf_init0_ack", ack_o, 1'b0);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      chk($sformatf("mf_init%0d_busy", i), busy_o, 1'b1);
      chk($sformatf("mf_init%0d_resp", i), resp_o, 1'b0);
    end
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    chk("mf_ready_ack", ack_o, 1'b1);
    chk("mf_ready_busy", busy_o, 1'b0);
    cyc(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
    chk("mf_r0_t1_resp", resp_o, 1'b0);
    idle();
    chk("mf_r0_resp", resp_o, 1'b1);
    chk("mf_r0_rdata", rdata_o, 32'h0);
    idle();
    chk("mf_r8_resp", resp_o, 1'b1);
    chk("mf_r8_rdata", rdata_o, 32'h0);
    idle();
    chk("mf_end_resp", resp_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024: memory size in 32-bit words; power of two, at least 4.
REQ-002 Parameter BASE_ADDR, default 32'h0: byte address of word 0; aligned to 4*DEPTH.
REQ-003 Parameter RD_LAT, default 2: read latency in cycles from acceptance to response; legal range 1..4.
REQ-004 Port clk_i  input  1  clock; all state changes on rising edge.
REQ-005 Port rst_i  input  1  reset; synchronous and active-low (0 = reset).
REQ-006 Port req_i  input  1  MemSplit32 request valid from master.
REQ-007 Port ack_o  output  1  request accepted this cycle.
REQ-008 Port we_i  input  1  1 = write, 0 = read.
REQ-009 Port addr_i  input  32  byte address.
REQ-010 Port wdata_i  input  32  write data.
REQ-011 Port be_i  input  4  byte enables; bit n selects wdata_i[8n+7:8n].
REQ-012 Port resp_o  output  1  read response valid, one-cycle pulse per read.
REQ-013 Port rdata_o  output  32  read data, qualified by resp_o.
REQ-014 Port stall_i  input  1  wait-state injection; 1 forces ack_o low.
REQ-015 Port busy_o  output  1  1 while memory initialisation runs.

Function
REQ-016 The block SHALL be the slave end of MemSplit32: the master drives req/we/addr/wdata/be; this block drives ack/resp/rdata.
REQ-017 FSM SHALL have two states: INIT and READY.
REQ-018 INIT SHALL write 32'h0 to one word per cycle (index 0..DEPTH-1), then go to READY; INIT lasts exactly DEPTH cycles.
REQ-019 In INIT: ack_o=0 and busy_o=1, regardless of req_i or stall_i. In READY: busy_o=0.
REQ-020 In READY, ack_o SHALL be combinational: req_i & ~stall_i. A request is accepted in any cycle where req_i=1 and ack_o=1.
REQ-021 Address is in range iff BASE_ADDR <= addr_i < BASE_ADDR+4*DEPTH; word index = (addr_i-BASE_ADDR)>>2; addr_i[1:0] ignored.
REQ-022 Accepted in-range write SHALL update only the bytes with be_i set, at the acceptance edge; it produces no resp_o pulse.
REQ-023 Accepted write with be_i=0, or any out-of-range write, SHALL leave memory unchanged.
REQ-024 Accepted read SHALL produce resp_o=1 for exactly one cycle, RD_LAT cycles after the acceptance cycle (acceptance at cycle t gives resp at t+RD_LAT); be_i is ignored.
REQ-025 Read data SHALL reflect all writes accepted in earlier cycles; a write at t followed by a read of the same word at t+1 returns the new data.
REQ-026 Out-of-range read SHALL return 32'hDEADBEEF with the same latency.
REQ-027 Reads SHALL be fully pipelined: one read accepted per cycle gives one response per cycle, in acceptance order, with no bubbles.
REQ-028 rdata_o SHALL be 32'h0 in every cycle where resp_o=0.
REQ-029 Interleaved reads and writes SHALL keep the latency of every read unchanged.
REQ-030 stall_i=1 affects acceptance only; responses already in flight SHALL still emerge on schedule.

Reset
REQ-031 While rst_i=0 at a rising edge: FSM->INIT, init counter->0, response pipeline cleared.
REQ-032 Output values under reset: ack_o=0, resp_o=0, rdata_o=32'h0, busy_o=1.
REQ-033 Reset asserted mid-operation SHALL drop all in-flight reads (no resp_o pulse after reset) and SHALL rerun full initialisation.

Verification
All scenarios use DEPTH=16, BASE_ADDR=0, RD_LAT=2 unless stated.
REQ-034 Init: release reset, hold req_i=1 -> busy_o=1 and ack_o=0 for 16 cycles; then ack_o=1; a read of 0x3C returns 0x00000000.
REQ-035 Byte enables:
- write 0x11223344 to 0x8 with be=F, then write 0xAABBCCDD to 0x8 with be=2;
- read 0x8 accepted at cycle t -> resp_o=1 at t+2 with rdata 0x1122CC44.
REQ-036 Range:
- read 0x40 -> 0xDEADBEEF at t+2;
- write 0x5 to 0x40, then read 0x0 -> 0x00000000.
REQ-037 Streaming: write words 0..3 with values 0xA0..0xA3, then 4 back-to-back reads -> 4 consecutive resp_o cycles carrying 0xA0, 0xA1, 0xA2, 0xA3.
REQ-038 Stall:
- stall_i=1 for 3 cycles with req_i=1 -> ack_o=0 throughout;
- a read accepted just before the stall still responds at t+2.
REQ-039 Reset mid-flight: accept a read, assert rst_i=0 on the next cycle -> no resp_o pulse; busy_o=1 for 16 cycles; prior data reads back as 0.
